// File: rtl/mem_access_ahb_pkg.sv
// Shared encodings for the AHB-Lite memory stage: funct3 codes, bus
// encodings, FSM states and the funct3 -> transfer size helper.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_B = 3'b000;
    localparam logic [2:0] HSIZE_H = 3'b001;
    localparam logic [2:0] HSIZE_W = 3'b010;
    localparam logic [2:0] HSIZE_D = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WADDR,
        S_WDATA,
        S_DONE
    } state_t;

    // The low two funct3 bits are log2 of the access size in bytes.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        return {1'b0, funct3[1:0]};
    endfunction

endpackage

// File: rtl/mem_access_ahb_lane_align.sv
// Byte-lane steering between the register view and the bus view:
// load extract + sign/zero extend, RMW merge, and direct-store replication.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OW   = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] wdata,
    input  logic [OW-1:0]   off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] load_val,
    output logic [XLEN-1:0] merged,
    output logic [XLEN-1:0] repl
);

    localparam logic [2:0] MAX_SZ = (XLEN == 64) ? HSIZE_D : HSIZE_W;

    logic [2:0]      sz;
    logic [XLEN-1:0] rsh;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] mask;

    // Steer the addressed lane down for loads and the store data up for merges.
    always_comb begin
        sz = size_of(funct3);
        if (sz > MAX_SZ) sz = MAX_SZ;
        rsh       = rdata >> {off, 3'b000};
        load_val  = rsh;
        lane_mask = '1;
        repl      = wdata;
        case (sz)
            HSIZE_B: begin
                load_val  = funct3[2] ? XLEN'(rsh[7:0]) : XLEN'($signed(rsh[7:0]));
                lane_mask = XLEN'(8'hFF);
                repl      = {(XLEN/8){wdata[7:0]}};
            end
            HSIZE_H: begin
                load_val  = funct3[2] ? XLEN'(rsh[15:0]) : XLEN'($signed(rsh[15:0]));
                lane_mask = XLEN'(16'hFFFF);
                repl      = {(XLEN/16){wdata[15:0]}};
            end
            HSIZE_W: begin
                load_val  = funct3[2] ? XLEN'(rsh[31:0]) : XLEN'($signed(rsh[31:0]));
                lane_mask = XLEN'(32'hFFFF_FFFF);
                repl      = {(XLEN/32){wdata[31:0]}};
            end
            default: ;
        endcase
        mask   = lane_mask << {off, 3'b000};
        merged = (rdata & ~mask) | ((wdata << {off, 3'b000}) & mask);
    end

endmodule

// File: rtl/mem_access_ahb.sv
// Execute-to-writeback memory stage issuing RV loads/stores as AHB-Lite
// transfers, with optional read-modify-write for sub-word stores,
// misalignment trapping and branch-shadow squashing.
module mem_access_ahb
    import mem_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int AW            = 32,
    parameter int RW            = 5,
    parameter int RMW_STORES    = 1,
    parameter int MISALIGN_TRAP = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            req_i,
    input  logic            mem_en_i,
    input  logic            load_i,
    input  logic [2:0]      funct3_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] alu_res_i,
    input  logic [RW-1:0]   rd_i,
    input  logic            wb_i,
    input  logic            branch_i,
    input  logic [AW-1:0]   branch_off_i,
    input  logic [AW-1:0]   pc_i,
    output logic            busy_o,
    output logic [AW-1:0]   HADDR,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADY,
    input  logic            HRESP,
    output logic            valid_o,
    output logic [XLEN-1:0] res_o,
    output logic [RW-1:0]   rd_o,
    output logic            wb_en_o,
    output logic            take_branch_o,
    output logic [AW-1:0]   branch_off_o,
    output logic [AW-1:0]   pc_o,
    output logic            misalign_o,
    output logic            bus_err_o
);

    localparam int         NB       = XLEN/8;
    localparam int         OW       = $clog2(NB);
    localparam logic [2:0] BUS_SIZE = (XLEN == 64) ? HSIZE_D : HSIZE_W;

    state_t state, next_state;

    // Operation latched at accept, consumed by the later bus phases.
    logic            load_q, wb_q, rmw_q;
    logic [2:0]      f3_q;
    logic [OW-1:0]   off_q;
    logic [RW-1:0]   rd_q;
    logic [XLEN-1:0] wdata_q;

    logic            accept, squash, misaligned, trap, mem_go, rmw_in;
    logic [2:0]      sz_in;
    logic [AW-1:0]   addr_eff, bus_addr;
    logic [XLEN-1:0] load_val, merged, repl;

    assign busy_o     = (state != S_IDLE);
    assign accept     = req_i && (state == S_IDLE);
    // The instruction in the shadow of a taken branch must not take effect.
    assign squash     = take_branch_o;
    assign sz_in      = size_of(funct3_i);
    assign misaligned = (sz_in == HSIZE_H && addr_i[0]) ||
                        (sz_in == HSIZE_W && addr_i[1:0] != 2'b00) ||
                        (sz_in == HSIZE_D && addr_i[2:0] != 3'b000);
    assign trap       = (MISALIGN_TRAP != 0) && misaligned;
    assign mem_go     = accept && !squash && mem_en_i && !trap;
    // Sub-bus stores go through a full-bus read then write when RMW is on.
    assign rmw_in     = (RMW_STORES != 0) && !load_i && (sz_in < BUS_SIZE);
    // Without trapping, a misaligned address simply loses its low bits.
    assign addr_eff   = addr_i & ~((AW'(1) << sz_in) - AW'(1));
    assign bus_addr   = rmw_in ? (addr_i & ~AW'(NB-1)) : addr_eff;

    mem_lane_align #(.XLEN(XLEN), .OW(OW)) u_align (
        .rdata    (HRDATA),
        .wdata    (wdata_q),
        .off      (off_q),
        .funct3   (f3_q),
        .load_val (load_val),
        .merged   (merged),
        .repl     (repl)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state: each bus phase advances only on HREADY.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (mem_go) next_state = S_ADDR;
            S_ADDR:  if (HREADY) next_state = S_DATA;
            S_DATA:  if (HREADY) next_state = (rmw_q && !HRESP) ? S_WADDR : S_DONE;
            S_WADDR: if (HREADY) next_state = S_WDATA;
            S_WDATA: if (HREADY) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Registered bus outputs, writeback results and latched operation fields.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            HTRANS        <= HTRANS_IDLE;
            HWRITE        <= 1'b0;
            HADDR         <= '0;
            HWDATA        <= '0;
            HSIZE         <= HSIZE_B;
            valid_o       <= 1'b0;
            wb_en_o       <= 1'b0;
            take_branch_o <= 1'b0;
            misalign_o    <= 1'b0;
            bus_err_o     <= 1'b0;
            res_o         <= '0;
            rd_o          <= '0;
            branch_off_o  <= '0;
            pc_o          <= '0;
            load_q        <= 1'b0;
            wb_q          <= 1'b0;
            rmw_q         <= 1'b0;
            f3_q          <= '0;
            off_q         <= '0;
            rd_q          <= '0;
            wdata_q       <= '0;
        end else begin
            valid_o    <= 1'b0;
            wb_en_o    <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            if (accept) begin
                take_branch_o <= branch_i && (alu_res_i == XLEN'(1)) && !squash;
                branch_off_o  <= branch_off_i;
                pc_o          <= pc_i;
                load_q        <= load_i;
                wb_q          <= wb_i;
                rmw_q         <= rmw_in;
                f3_q          <= funct3_i;
                off_q         <= addr_eff[OW-1:0];
                rd_q          <= rd_i;
                wdata_q       <= wdata_i;
                if (squash) begin
                    valid_o <= 1'b1;
                    rd_o    <= '0;
                end else if (!mem_en_i) begin
                    valid_o <= 1'b1;
                    res_o   <= alu_res_i;
                    rd_o    <= rd_i;
                    wb_en_o <= wb_i;
                end else if (trap) begin
                    valid_o    <= 1'b1;
                    misalign_o <= 1'b1;
                    rd_o       <= rd_i;
                end else begin
                    HTRANS <= HTRANS_NONSEQ;
                    HADDR  <= bus_addr;
                    HWRITE <= !load_i && !rmw_in;
                    HSIZE  <= rmw_in ? BUS_SIZE : sz_in;
                end
            end
            case (state)
                S_ADDR: if (HREADY) begin
                    HTRANS <= HTRANS_IDLE;
                    if (HWRITE) HWDATA <= repl;
                end
                S_DATA: if (HREADY) begin
                    if (HRESP) begin
                        valid_o   <= 1'b1;
                        bus_err_o <= 1'b1;
                        rd_o      <= rd_q;
                    end else if (rmw_q) begin
                        // Write phase reuses the word-aligned HADDR of the read.
                        HTRANS <= HTRANS_NONSEQ;
                        HWRITE <= 1'b1;
                        HSIZE  <= BUS_SIZE;
                        HWDATA <= merged;
                    end else begin
                        valid_o <= 1'b1;
                        wb_en_o <= wb_q && load_q;
                        rd_o    <= rd_q;
                        if (load_q) res_o <= load_val;
                    end
                end
                S_WADDR: if (HREADY) HTRANS <= HTRANS_IDLE;
                S_WDATA: if (HREADY) begin
                    valid_o   <= 1'b1;
                    bus_err_o <= HRESP;
                    rd_o      <= rd_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_ahb.md
Name: mem_access_ahb

Overview:
- Parametrised successor of the execute-to-writeback memory stage.
- Performs RV32 loads and stores as real AHB-Lite transfers, with a proper address phase, a data phase, HREADY wait states and a pipeline stall output.
- Supports two store modes: read-modify-write, or native sized writes.
- Detects misalignment, resolves branches and squashes the shadow instruction.
- Sits between the ALU stage and the register-file writeback.

Parameters:
- XLEN, 32, data and bus width; must be 32 or 64.
- AW, 32, address width.
- RW, 5, register-index width.
- RMW_STORES, 1. When 1, SB/SH/SH-type stores run a read then a full-word write. When 0, a single write with HSIZE set and lane-replicated HWDATA.
- MISALIGN_TRAP, 1. When 1, misaligned accesses raise misalign_o and perform no bus access. When 0, the address is forced aligned.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous active-high reset.
- req_i  in  1  instruction valid from the ALU stage.
- mem_en_i  in  1  instruction accesses memory.
- load_i  in  1  1 = load, 0 = store (meaningful when mem_en_i=1).
- funct3_i  in  3  RV funct3: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only).
- addr_i  in  AW  effective address.
- wdata_i  in  XLEN  store data.
- alu_res_i  in  XLEN  ALU result.
- rd_i  in  RW  destination register.
- wb_i  in  1  writeback request.
- branch_i  in  1  instruction is a branch.
- branch_off_i  in  AW  branch offset.
- pc_i  in  AW  program counter.
- busy_o  out  1  stall upstream; combinational (state != IDLE).
- HADDR  out  AW  AHB address.
- HTRANS  out  2  AHB transfer type: IDLE 00, NONSEQ 10.
- HWRITE  out  1  AHB write.
- HSIZE  out  3  AHB transfer size.
- HWDATA  out  XLEN  AHB write data.
- HRDATA  in  XLEN  AHB read data.
- HREADY  in  1  AHB ready.
- HRESP  in  1  AHB error response.
- valid_o  out  1  result valid, one-cycle pulse.
- res_o  out  XLEN  writeback value.
- rd_o  out  RW  writeback register.
- wb_en_o  out  1  writeback enable.
- take_branch_o  out  1  branch taken.
- branch_off_o  out  AW  registered branch offset.
- pc_o  out  AW  registered program counter.
- misalign_o  out  1  misalignment exception, pulse.
- bus_err_o  out  1  bus error exception, pulse.

Behaviour:
Reset (synchronous, RESET=1 at a posedge):
- state=IDLE.
- HTRANS=00, HWRITE=0, HADDR=0, HWDATA=0, HSIZE=0.
- valid_o, wb_en_o, take_branch_o, misalign_o, bus_err_o = 0.
- res_o=0, rd_o=0, branch_off_o=0, pc_o=0.
- Reset overrides any in-flight transfer. HTRANS returns to IDLE the next cycle; no result is produced.

Acceptance:
- An instruction is accepted when req_i=1 and state=IDLE.

Squash:
- If take_branch_o=1 in the accept cycle, the instruction is squashed: valid_o=1, wb_en_o=0, rd_o=0, no bus access.

Registered every accept:
- take_branch_o <= branch_i && alu_res_i==1 && !squash.
- branch_off_o, pc_o registered.

Non-memory instruction (mem_en_i=0):
- 1-cycle latency: res_o=alu_res_i, rd_o, wb_en_o=wb_i, valid_o=1.

Misaligned access:
- Misaligned means H with addr[0]!=0, W with addr[1:0]!=0, or D with addr[2:0]!=0.
- With MISALIGN_TRAP=1: no transfer; valid_o=1, wb_en_o=0, misalign_o=1.

FSM states and transitions:
- IDLE → ADDR on an accepted memory op.
- ADDR: HTRANS=NONSEQ, HADDR=addr_i (aligned to the word when RMW_STORES=1 and the access is sub-word), HWRITE=!load && !rmw, HSIZE per the table below. Advances to DATA at the next edge if HREADY=1, otherwise holds. HTRANS is driven IDLE on leaving.
- DATA: waits for HREADY=1.
  - Load: extract the lane by addr low bits, sign- or zero-extend per funct3, go to DONE.
  - RMW store: merge the wdata byte/half into HRDATA lanes, go to WADDR.
  - Direct store: go to DONE.
- WADDR: HTRANS=NONSEQ, HWRITE=1, HSIZE=word; → WDATA when HREADY=1.
- WDATA: HWDATA = merged word; → DONE when HREADY=1.
- DONE: valid_o=1, wb_en_o = wb_i && load; → IDLE.
- Bus error: HRESP=1 with HREADY=1 in DATA or WDATA → DONE with bus_err_o=1, wb_en_o=0.

Latency with zero-wait slaves (HREADY=1):
- Load: valid_o 3 cycles after accept.
- Direct store: valid_o 3 cycles after accept.
- RMW store: valid_o 5 cycles after accept.
- Each HREADY-low cycle adds 1.

Data and size rules:
- HWDATA is valid in the cycle after the matching address phase, per AHB.
- Direct stores replicate the byte/half across all lanes.
- HSIZE: B=000, H=001, W=010, D=011.

Decomposition:
- Package mem_pkg: funct3 codes, HTRANS and HSIZE encodings, FSM state enum, and the function size_of(funct3).
- Sub-module mem_lane_align (combinational): load extract/extend, and store merge/replicate, parametrised on XLEN.

Test Plan:
1. LB, addr=0x1003, HRDATA=0x80FF_0000, HREADY=1 → HADDR=0x1003, HSIZE=000; 3 cycles later res_o=0xFFFF_FF80, wb_en_o=1.
2. SB with RMW_STORES=1, addr=0x2001, wdata=0xAB, read returns 0x1122_3344 → second transfer HWRITE=1, HADDR=0x2000, HWDATA=0x1122_AB44; valid_o at cycle 5.
3. LW with HREADY low for 2 data-phase cycles → busy_o=1 throughout, res_o valid at cycle 5, HTRANS=00 during the waits.
4. SH at addr=0x3001, MISALIGN_TRAP=1 → HTRANS stays 00, misalign_o=1, wb_en_o=0 after 1 cycle.
5. Branch with alu_res_i=1, followed by ADD rd=5 → take_branch_o=1; the next result has rd_o=0, wb_en_o=0.
6. RESET=1 asserted during DATA of a load → the next cycle has HTRANS=00, valid_o=0, state IDLE; a following load completes normally.
